// File: rtl/linear_1d_accumulator.sv
// linear_1d_accumulator
//   Streaming dot-product accumulator + bias adder for the 1-D linear datapath.
//   Sums a group of signed products (delimited by IN_LAST), adds one bias word
//   from the bias stream, range-converts to DATA_WIDTH and emits one result per
//   group. OUT_LAST marks the last neuron of a layer (NUM_OUTPUTS results).
//
//   Optional feature: define LINEAR_1D_ACCUM_SATURATE_EN to clamp out-of-range
//   results to the DATA_WIDTH extremes; otherwise results wrap (truncate).
//   OUT_OVERFLOW flags out-of-range results in both builds.
//
// Ports
//   CLK, RESET_N              clock, async active-low reset
//   NUM_OUTPUTS[15:0]         results per layer (0/1 -> every result is last)
//   IN_*                      product stream (valid/ready, USER, LAST)
//   BIAS_*                    bias stream (valid/ready)
//   OUT_*                     result stream (valid/ready, USER, LAST, OVERFLOW)
module linear_1d_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = DATA_WIDTH/8,
  parameter int ACC_GUARD  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [15:0]           NUM_OUTPUTS,
  output logic                  IN_READY,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [USER_WIDTH-1:0] IN_USER,
  input  logic                  IN_LAST,
  output logic                  BIAS_READY,
  input  logic                  BIAS_VALID,
  input  logic [DATA_WIDTH-1:0] BIAS_DATA,
  input  logic                  OUT_READY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [USER_WIDTH-1:0] OUT_USER,
  output logic                  OUT_LAST,
  output logic                  OUT_OVERFLOW
);

  localparam int ACC_WIDTH = DATA_WIDTH + ACC_GUARD;

  typedef enum logic [1:0] {S_ACC, S_BIAS, S_OUT} state_t;

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   first;
  logic [USER_WIDTH-1:0]  user_q;
  logic [15:0]            cnt;
  logic [15:0]            last_idx;

  logic                   in_fire, bias_fire, out_fire;
  logic [ACC_WIDTH-1:0]   in_sext, bias_sext, sum;
  logic                   ovf;
  logic [DATA_WIDTH-1:0]  conv;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_ACC;
    else          state <= state_nxt;
  end

  // Ready strobes depend on state only, so no input-to-ready comb path.
  always_comb begin
    state_nxt  = state;
    IN_READY   = 1'b0;
    BIAS_READY = 1'b0;
    case (state)
      S_ACC: begin
        IN_READY = 1'b1;
        if (IN_VALID && IN_LAST) state_nxt = S_BIAS;
      end
      S_BIAS: begin
        BIAS_READY = 1'b1;
        if (BIAS_VALID) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (OUT_READY) state_nxt = S_ACC;
      end
      default: state_nxt = S_ACC;
    endcase
  end

  // ---------------- datapath ----------------
  assign in_fire   = IN_VALID & IN_READY;
  assign bias_fire = BIAS_VALID & BIAS_READY;
  assign out_fire  = (state == S_OUT) & OUT_READY;

  assign in_sext   = {{ACC_GUARD{IN_DATA[DATA_WIDTH-1]}}, IN_DATA};
  assign bias_sext = {{ACC_GUARD{BIAS_DATA[DATA_WIDTH-1]}}, BIAS_DATA};
  assign sum       = acc + bias_sext;

  // In range iff all bits from the DATA_WIDTH sign bit upward agree.
  assign ovf = ~(&sum[ACC_WIDTH-1:DATA_WIDTH-1]) & (|sum[ACC_WIDTH-1:DATA_WIDTH-1]);

`ifdef LINEAR_1D_ACCUM_SATURATE_EN
  // Overflow implies a nonzero sum, so the sign bit alone picks the rail.
  assign conv = !ovf                ? sum[DATA_WIDTH-1:0] :
                sum[ACC_WIDTH-1]    ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                      {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  assign conv = sum[DATA_WIDTH-1:0];
`endif

  assign last_idx = (NUM_OUTPUTS == 16'd0) ? 16'd0 : NUM_OUTPUTS - 16'd1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc          <= '0;
      first        <= 1'b1;
      user_q       <= '0;
      cnt          <= '0;
      OUT_VALID    <= 1'b0;
      OUT_DATA     <= '0;
      OUT_USER     <= '0;
      OUT_LAST     <= 1'b0;
      OUT_OVERFLOW <= 1'b0;
    end else begin
      if (in_fire) begin
        acc   <= (first ? '0 : acc) + in_sext;
        first <= IN_LAST;
        if (IN_LAST) user_q <= IN_USER;
      end
      if (bias_fire) begin
        OUT_VALID    <= 1'b1;
        OUT_DATA     <= conv;
        OUT_OVERFLOW <= ovf;
        OUT_USER     <= user_q;
        OUT_LAST     <= (cnt == last_idx);
      end
      if (out_fire) begin
        OUT_VALID <= 1'b0;
        cnt       <= OUT_LAST ? 16'd0 : cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_linear_1d_accumulator.sv
// Self-checking bench for linear_1d_accumulator (DATA_WIDTH=8, ACC_GUARD=8).
// Expected results are pushed to a scoreboard when a group is driven and
// popped by a monitor when the DUT hands a result off.
module tb_linear_1d_accumulator;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] NUM_OUTPUTS;
  logic        IN_READY, IN_VALID, IN_LAST;
  logic [7:0]  IN_DATA;
  logic [3:0]  IN_USER;
  logic        BIAS_READY, BIAS_VALID;
  logic [7:0]  BIAS_DATA;
  logic        OUT_READY, OUT_VALID, OUT_LAST, OUT_OVERFLOW;
  logic [7:0]  OUT_DATA;
  logic [3:0]  OUT_USER;

  linear_1d_accumulator #(.DATA_WIDTH(8), .USER_WIDTH(4), .ACC_GUARD(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .NUM_OUTPUTS(NUM_OUTPUTS),
    .IN_READY(IN_READY), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_USER(IN_USER), .IN_LAST(IN_LAST),
    .BIAS_READY(BIAS_READY), .BIAS_VALID(BIAS_VALID), .BIAS_DATA(BIAS_DATA),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .OUT_USER(OUT_USER), .OUT_LAST(OUT_LAST), .OUT_OVERFLOW(OUT_OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] user;
    logic       last;
    logic       ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] tb_cnt = 16'd0;
  int          pv[16];
  bit          done;

  // ---------------- reference model ----------------
  function automatic exp_t model(input int total, input logic [3:0] u, input logic last);
    exp_t e;
    logic signed [15:0] s;
    s      = 16'(total);
    e.ovf  = (s > 16'sd127) || (s < -16'sd128);
`ifdef LINEAR_1D_ACCUM_SATURATE_EN
    e.data = !e.ovf ? s[7:0] : (s < 0 ? 8'h80 : 8'h7f);
`else
    e.data = s[7:0];
`endif
    e.user = u;
    e.last = last;
    return e;
  endfunction

  task automatic push_exp(input int total, input logic [3:0] u);
    logic [15:0] li;
    logic        l;
    li = (NUM_OUTPUTS == 16'd0) ? 16'd0 : NUM_OUTPUTS - 16'd1;
    l  = (tb_cnt == li);
    tb_cnt = l ? 16'd0 : tb_cnt + 16'd1;
    sb.push_back(model(total, u, l));
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output got data=%h, none expected", OUT_DATA);
      end else begin
        me = sb.pop_front();
        tests++;
        if (OUT_DATA !== me.data) begin
          fails++; $display("FAIL out_data got %h want %h", OUT_DATA, me.data);
        end
        tests++;
        if (OUT_USER !== me.user) begin
          fails++; $display("FAIL out_user got %h want %h", OUT_USER, me.user);
        end
        tests++;
        if (OUT_LAST !== me.last) begin
          fails++; $display("FAIL out_last got %b want %b (data %h)", OUT_LAST, me.last, me.data);
        end
        tests++;
        if (OUT_OVERFLOW !== me.ovf) begin
          fails++; $display("FAIL out_overflow got %b want %b (data %h)", OUT_OVERFLOW, me.ovf, me.data);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic [7:0] d, input logic [3:0] u, input logic l);
    int t = 0;
    IN_VALID = 1'b1; IN_DATA = d; IN_USER = u; IN_LAST = l;
    @(negedge CLK);
    while (IN_READY !== 1'b1 && t < 200) begin @(negedge CLK); t++; end
    if (IN_READY !== 1'b1) begin
      tests++; fails++; $display("FAIL in_ready_timeout got %b want 1", IN_READY);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
  endtask

  task automatic drive_bias(input logic [7:0] b);
    int t = 0;
    BIAS_VALID = 1'b1; BIAS_DATA = b;
    @(negedge CLK);
    while (BIAS_READY !== 1'b1 && t < 200) begin @(negedge CLK); t++; end
    if (BIAS_READY !== 1'b1) begin
      tests++; fails++; $display("FAIL bias_ready_timeout got %b want 1", BIAS_READY);
    end
    @(posedge CLK); #1;
    BIAS_VALID = 1'b0;
    tests++;
    if (OUT_VALID !== 1'b1) begin
      fails++; $display("FAIL bias_to_valid_latency got %b want 1", OUT_VALID);
    end
  endtask

  task automatic send_group(input int n, input logic [3:0] u, input int bias, input int gap_max);
    int total = bias;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge CLK); #1; end
      drive_beat(8'(pv[i]), u, i == n-1);
      total += pv[i];
    end
    push_exp(total, u);
    drive_bias(8'(bias));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge CLK); t++; end
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL drain got %0d pending want 0", sb.size());
    end
    @(posedge CLK); #1;
  endtask

  task automatic pulse_reset();
    IN_VALID = 1'b0; BIAS_VALID = 1'b0;
    RESET_N = 1'b0;
    sb.delete();
    tb_cnt = 16'd0;
    #4 RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET_N = 1'b0; NUM_OUTPUTS = 16'd1;
    IN_VALID = 0; IN_DATA = 0; IN_USER = 0; IN_LAST = 0;
    BIAS_VALID = 0; BIAS_DATA = 0; OUT_READY = 1'b1;
    #2;
    tests++; if (OUT_VALID !== 1'b0)    begin fails++; $display("FAIL rst_out_valid got %b want 0", OUT_VALID); end
    tests++; if (OUT_DATA !== 8'h00)    begin fails++; $display("FAIL rst_out_data got %h want 00", OUT_DATA); end
    tests++; if (OUT_USER !== 4'h0)     begin fails++; $display("FAIL rst_out_user got %h want 0", OUT_USER); end
    tests++; if (OUT_LAST !== 1'b0)     begin fails++; $display("FAIL rst_out_last got %b want 0", OUT_LAST); end
    tests++; if (OUT_OVERFLOW !== 1'b0) begin fails++; $display("FAIL rst_out_ovf got %b want 0", OUT_OVERFLOW); end
    tests++; if (IN_READY !== 1'b1)     begin fails++; $display("FAIL rst_in_ready got %b want 1", IN_READY); end
    tests++; if (BIAS_READY !== 1'b0)   begin fails++; $display("FAIL rst_bias_ready got %b want 0", BIAS_READY); end
    #10 RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    NUM_OUTPUTS = 16'd1;
    pv[0] = 3; pv[1] = -5; pv[2] = 10;
    send_group(3, 4'd2, 4, 0);
    drain();
  endtask

  task automatic test_overflow();
    pv[0] = 100; pv[1] = 100;
    send_group(2, 4'd1, 0, 0);
    pv[0] = -100; pv[1] = -100;
    send_group(2, 4'd3, 0, 0);
    pv[0] = 127; pv[1] = 1;
    send_group(2, 4'd4, -1, 0);
    drain();
  endtask

  task automatic test_layer_count();
    pulse_reset();
    NUM_OUTPUTS = 16'd3;
    for (int i = 0; i < 5; i++) begin
      pv[0] = i + 1;
      send_group(1, 4'(i), 0, 0);
    end
    drain();
    pulse_reset();
    NUM_OUTPUTS = 16'd0;
    for (int i = 0; i < 3; i++) begin
      pv[0] = 10 * i;
      send_group(1, 4'(i), 2, 0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    NUM_OUTPUTS = 16'd1;
    OUT_READY = 1'b0;
    pv[0] = 20; pv[1] = 30;
    send_group(2, 4'd5, 1, 0);
    IN_VALID = 1'b1; IN_DATA = 8'd99; IN_LAST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      tests++; if (OUT_VALID !== 1'b1)  begin fails++; $display("FAIL bp_valid c%0d got %b want 1", c, OUT_VALID); end
      tests++; if (OUT_DATA !== 8'd51)  begin fails++; $display("FAIL bp_data c%0d got %h want 33", c, OUT_DATA); end
      tests++; if (OUT_USER !== 4'd5)   begin fails++; $display("FAIL bp_user c%0d got %h want 5", c, OUT_USER); end
      tests++; if (IN_READY !== 1'b0)   begin fails++; $display("FAIL bp_in_ready c%0d got %b want 0", c, IN_READY); end
      tests++; if (BIAS_READY !== 1'b0) begin fails++; $display("FAIL bp_bias_ready c%0d got %b want 0", c, BIAS_READY); end
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    OUT_READY = 1'b1;
    drain();
    // Bias offered early must wait for the group to finish.
    BIAS_VALID = 1'b1; BIAS_DATA = 8'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      tests++; if (BIAS_READY !== 1'b0) begin fails++; $display("FAIL early_bias_ready c%0d got %b want 0", c, BIAS_READY); end
    end
    @(posedge CLK); #1;
    drive_beat(8'd1, 4'd3, 1'b0);
    drive_beat(8'd2, 4'd3, 1'b1);
    push_exp(8, 4'd3);
    drive_bias(8'd5);
    drain();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    NUM_OUTPUTS = 16'd2;
    pv[0] = 9;
    send_group(1, 4'd6, 0, 0);
    drain();
    drive_beat(8'd50, 4'd1, 1'b0);
    drive_beat(8'd60, 4'd1, 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    tests++; if (OUT_DATA !== 8'h00)  begin fails++; $display("FAIL arst_data got %h want 00", OUT_DATA); end
    tests++; if (OUT_USER !== 4'h0)   begin fails++; $display("FAIL arst_user got %h want 0", OUT_USER); end
    tests++; if (OUT_VALID !== 1'b0)  begin fails++; $display("FAIL arst_valid got %b want 0", OUT_VALID); end
    tests++; if (IN_READY !== 1'b1)   begin fails++; $display("FAIL arst_in_ready got %b want 1", IN_READY); end
    sb.delete();
    tb_cnt = 16'd0;
    #3 RESET_N = 1'b1;
    @(posedge CLK); #1;
    pv[0] = 7;
    send_group(1, 4'd7, 1, 0);
    drain();
  endtask

  task automatic test_random();
    pulse_reset();
    NUM_OUTPUTS = 16'd4;
    done = 1'b0;
    fork
      begin
        for (int g = 0; g < 25; g++) begin
          int n;
          n = $urandom_range(1, 16);
          for (int i = 0; i < n; i++) pv[i] = int'($urandom_range(0, 255)) - 128;
          send_group(n, 4'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128, 2);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          OUT_READY = 1'($urandom_range(0, 1));
          @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_layer_count();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/linear_1d_accumulator.md
# linear_1d_accumulator

Streaming dot-product accumulator and bias adder for the 1-D linear (fully-connected) datapath. It sits directly upstream of the activation stage. It sums a group of signed products delimited by `IN_LAST`, adds one bias word taken from a separate bias stream, range-converts the sum to `DATA_WIDTH`, and emits one result per group on a valid/ready output. It also marks the last neuron of a layer with `OUT_LAST`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of products, bias and result (2's complement integer).
- `USER_WIDTH`, `DATA_WIDTH/8`: sideband width.
- `ACC_GUARD`, 8: guard bits; accumulator width `ACC_WIDTH = DATA_WIDTH + ACC_GUARD`.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `NUM_OUTPUTS`  in  16  results per layer; 0 or 1 means every result is last. Static while busy.
- `IN_READY`  out  1  product stream ready.
- `IN_VALID`  in  1  product valid.
- `IN_DATA`  in  `DATA_WIDTH`  signed product.
- `IN_USER`  in  `USER_WIDTH`  sideband.
- `IN_LAST`  in  1  last product of a group.
- `BIAS_READY`  out  1  bias stream ready.
- `BIAS_VALID`  in  1  bias valid.
- `BIAS_DATA`  in  `DATA_WIDTH`  signed bias.
- `OUT_READY`  in  1  downstream ready.
- `OUT_VALID`  out  1  result valid.
- `OUT_DATA`  out  `DATA_WIDTH`  result.
- `OUT_USER`  out  `USER_WIDTH`  `IN_USER` of the group's last beat.
- `OUT_LAST`  out  1  last result of a layer.
- `OUT_OVERFLOW`  out  1  result did not fit `DATA_WIDTH`; qualified by `OUT_VALID`.

## Operation
The block is a three-state FSM: `S_ACC`, `S_BIAS`, `S_OUT`. Reset state is `S_ACC`.

**`S_ACC`**
- `IN_READY=1`; `BIAS_READY=0`.
- A beat is accepted on `IN_VALID&IN_READY`.
- Accepted beat: `acc <= (first ? 0 : acc) + sext(IN_DATA)`. `first` is set after reset and after each group.
- Accepted beat with `IN_LAST`: latch `IN_USER` and go to `S_BIAS`.
- A one-beat group (`IN_LAST` on its first beat) is legal.

**`S_BIAS`**
- `IN_READY=0`; `BIAS_READY=1`.
- On `BIAS_VALID`: `sum = acc + sext(BIAS_DATA)` in `ACC_WIDTH` bits, wrapping modulo `2^ACC_WIDTH`.
- Register the converted `sum` into `OUT_DATA` and `OUT_OVERFLOW`.
- Set `OUT_VALID=1` and `OUT_LAST = (cnt == max(NUM_OUTPUTS,1) - 1)`.
- Go to `S_OUT`.

**`S_OUT`**
- `IN_READY=0`; `BIAS_READY=0`; outputs held stable.
- On `OUT_READY`: `OUT_VALID<=0` and go to `S_ACC`.
- The layer counter `cnt` advances on the same edge, or wraps to 0 if `OUT_LAST`.

**Conversion**
- Overflow exists when `sum` is outside `[-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]`.
- `OUT_OVERFLOW` is set whenever overflow exists, in both configurations.
- `OUT_DATA` on overflow is defined under Configuration.
- Guard-bit wrap of `acc` itself is not detected.

**Boundaries**
- A bias offered while in `S_ACC` waits, since `BIAS_READY=0`.
- Products offered while in `S_BIAS` or `S_OUT` wait, since `IN_READY=0`.
- Asserting `RESET_N` low mid-group or mid-output:
  - discards `acc`, `cnt` and any pending result;
  - returns the FSM to `S_ACC`;
  - sets `first=1`.

## Timing
- **Reset values:** `OUT_VALID=0`, `OUT_DATA=0`, `OUT_USER=0`, `OUT_LAST=0`, `OUT_OVERFLOW=0`, `IN_READY=1`, `BIAS_READY=0`.
- `IN_READY` and `BIAS_READY` are decoded from state only, with no combinational path from any input.
- **Latency:** bias-accept edge to `OUT_VALID=1` is 1 cycle.
- **Throughput:** an N-beat group with no stalls occupies N+2 cycles (N accept, 1 bias, 1 output).
- `OUT_*` remain stable while `OUT_VALID & ~OUT_READY`.

## Configuration
- Macro: `LINEAR_1D_ACCUM_SATURATE_EN`.
- **Defined:** on overflow, `OUT_DATA` clamps to `2^(DATA_WIDTH-1)-1` when `sum>0`, or to `-2^(DATA_WIDTH-1)` when `sum<0`.
- **Undefined:** `OUT_DATA = sum[DATA_WIDTH-1:0]` (truncation/wrap).
- `OUT_OVERFLOW` behaviour is identical in both configurations.

## Test plan
All scenarios use `DATA_WIDTH=8`, `ACC_GUARD=8`.
- **Basic:** products 3, -5, 10 (`LAST` on 10), `USER=2` on last; bias 4 -> `OUT_DATA=12`, `OUT_USER=2`, `OUT_OVERFLOW=0`, `OUT_VALID` one cycle after bias accept.
- **Overflow:** products 100, 100 (`LAST`), bias 0 -> `OUT_OVERFLOW=1`; `OUT_DATA=127` with macro, `0xC8` (-56) without. Products -100, -100, bias 0 -> 0x80 with macro, 0x38 without.
- **Layer count:** `NUM_OUTPUTS=3`, five one-beat groups -> `OUT_LAST` on results 3 only, then counter wraps. Also run `NUM_OUTPUTS=0` -> `OUT_LAST` on every result.
- **Backpressure:** hold `OUT_READY=0` for 4 cycles -> `OUT_*` stable, `IN_READY=0`, `BIAS_READY=0`. Bias presented early during `S_ACC` -> not consumed until `S_BIAS`.
- **Async reset:** assert `RESET_N` low between edges mid-group (after 2 of 4 beats) -> outputs cleared immediately. Next group 7 (`LAST`), bias 1 -> 8, no residue from the aborted group.
- **Random:** random groups of 1-16 beats with random valid/ready gaps -> outputs match a scoreboard of `sum(products)+bias` with the saturate/wrap rule.
